sram_stream_arbiter: RTL and testbench

Shares the single-port synchronous-read packet SRAM (ram_sp_sr_sw) between NUM_REQ requesters, normally the two mappers. A requester asks for the packet that starts at a given address. The block arbitrates round-robin and streams flits (data plus tail bit) from that address until the flit whose tail bit is set. Output is a valid/ready handshake. The block sits between the mapper front-ends and the RAM's cs/we/oe/address pins.

---
 rtl/sram_stream_arbiter_pkg.sv | 22 ++
 rtl/sram_stream_arbiter_if.sv | 64 ++++++
 rtl/sram_stream_arbiter_rr_arbiter.sv | 28 ++
 rtl/sram_stream_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_stream_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_stream_arbiter_pkg.sv
// Shared types, defaults and helpers for the SRAM stream arbiter.
package sram_arb_pkg;

    localparam int unsigned DataWidth = 16;
    localparam int unsigned AddrWidth = 8;

    localparam int unsigned DefNumReq   = 2;
    localparam int unsigned DefMaxFlits = 64;
    localparam int unsigned DefCntW     = 7;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStream
    } arb_state_e;

    // Requester that gets priority after idx has been served.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/sram_stream_arbiter_if.sv
// Requester-side stream handshake plus the SRAM pin bundle of the stream arbiter.
// master is the arbiter side; slave is the requester/RAM environment side.
interface sram_stream_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned ADDR_WIDTH = AddrWidth,
    parameter int unsigned DATA_WIDTH = DataWidth
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            out_valid;
    logic [NUM_REQ-1:0]            out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_tail;
    logic [NUM_REQ-1:0]            done;
    logic                          err_overrun;

    logic                          ram_cs;
    logic                          ram_we;
    logic                          ram_oe;
    logic [ADDR_WIDTH-1:0]         ram_address;
    logic [DATA_WIDTH-1:0]         ram_data_out;
    logic                          ram_tail_out;

    modport master (
        input  req,
        input  req_addr,
        input  out_ready,
        input  ram_data_out,
        input  ram_tail_out,
        output grant,
        output out_valid,
        output out_data,
        output out_tail,
        output done,
        output err_overrun,
        output ram_cs,
        output ram_we,
        output ram_oe,
        output ram_address
    );

    modport slave (
        output req,
        output req_addr,
        output out_ready,
        output ram_data_out,
        output ram_tail_out,
        input  grant,
        input  out_valid,
        input  out_data,
        input  out_tail,
        input  done,
        input  err_overrun,
        input  ram_cs,
        input  ram_we,
        input  ram_oe,
        input  ram_address
    );

endinterface

// File: rtl/sram_stream_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from rr_ptr upward and returns a one-hot winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IDX_W'((32'(rr_ptr) + off) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_stream_arbiter.sv
// Shares a single-port synchronous-read packet SRAM between requesters, streaming
// flits from a start address until the tail bit (or the flit cap) with valid/ready.
module sram_stream_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned MAX_FLITS  = DefMaxFlits,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned ADDR_WIDTH = AddrWidth
) (
    input logic                   clk,
    input logic                   rst_n,
    sram_stream_arbiter_if.master bus
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]       rr_q, rr_d;

    logic [NUM_REQ-1:0]    win;
    logic [IdxW-1:0]       grant_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  g_ready;
    logic                  last_flit;
    logic                  rd_en;
    logic                  finish;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_arbiter (
        .req    (bus.req),
        .rr_ptr (rr_q),
        .enable (state_q == StIdle),
        .winner (win)
    );

    always_comb begin
        grant_idx = '0;
        win_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) grant_idx = IdxW'(i);
            if (win[i])     win_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Only the owner's ready matters; everyone else's is masked off.
    assign g_ready   = |(bus.out_ready & grant_q);
    assign last_flit = bus.ram_tail_out || (cnt_q == CNT_W'(MAX_FLITS - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        rd_en   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    grant_d = win;
                    ptr_d   = win_addr;
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                rd_en   = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                state_d = StStream;
            end
            StStream: begin
                // A new read would overwrite the flit on the bus, so only read on acceptance.
                if (g_ready) begin
                    if (!last_flit) begin
                        rd_en = 1'b1;
                        ptr_d = ptr_q + 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        finish  = 1'b1;
                        grant_d = '0;
                        rr_d    = IdxW'(rr_next(32'(grant_idx), NUM_REQ));
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.out_valid   = (state_q == StStream) ? grant_q : '0;
    assign bus.out_data    = bus.ram_data_out;
    assign bus.out_tail    = bus.ram_tail_out;
    assign bus.done        = finish ? grant_q : '0;
    assign bus.err_overrun = finish & ~bus.ram_tail_out;

    assign bus.ram_cs      = rd_en;
    assign bus.ram_oe      = rd_en;
    assign bus.ram_we      = 1'b0;
    assign bus.ram_address = ptr_q;

endmodule

// File: tb/tb_sram_stream_arbiter.sv
// Randomised scoreboard bench for sram_stream_arbiter with a behavioural SRAM and packet model.
module tb_sram_stream_arbiter;
    import sram_arb_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned MF = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          tail;
        logic          last;
        logic          ovr;
        logic [AW-1:0] addr;
    } flit_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_stream_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_stream_arbiter #(
        .NUM_REQ    (NR),
        .MAX_FLITS  (MF),
        .CNT_W      (7),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem_data [256];
    logic          mem_tail [256];

    // Synchronous-read SRAM that holds its output between reads.
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_oe && !bus.ram_we) begin
            bus.ram_data_out <= mem_data[bus.ram_address];
            bus.ram_tail_out <= mem_tail[bus.ram_address];
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    flit_t q0[$];
    flit_t q1[$];

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int i, input flit_t f);
        if (i == 0) q0.push_back(f);
        else q1.push_back(f);
    endtask

    task automatic qpop(input int i, output flit_t f);
        if (i == 0) f = q0.pop_front();
        else f = q1.pop_front();
    endtask

    function automatic logic [AW-1:0] qfront_addr(input int i);
        return (i == 0) ? q0[0].addr : q1[0].addr;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int            done_cnt [NR];
    int            acc_cnt  [NR];
    int            cs_count = 0;
    int            rr_model = 0;
    logic [NR-1:0] grant_prev = '0;
    logic [NR-1:0] req_prev   = '0;
    logic [NR-1:0] done_prev  = '0;
    logic          fetch_prev = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_tail  = 1'b0;
    logic [NR-1:0] m_acc;
    logic [NR-1:0] m_done_exp;
    logic          m_ovr_exp;
    logic [AW-1:0] m_next;
    flit_t         m_f;
    int            m_w;

    initial begin
        for (int i = 0; i < NR; i++) begin
            done_cnt[i] = 0;
            acc_cnt[i]  = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            grant_prev = '0;
            done_prev  = '0;
            rr_model   = 0;
            fetch_prev = 1'b0;
            prev_stall = 1'b0;
            req_prev   = bus.req;
        end else begin
            check("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
            check("valid_outside_grant", bus.out_valid & ~bus.grant, 0);
            check("ram_we_zero", bus.ram_we, 0);
            check("ram_oe_eq_cs", bus.ram_oe, bus.ram_cs);
            if (fetch_prev) check("first_valid_latency", bus.out_valid, grant_prev);
            fetch_prev = 1'b0;
            if (grant_prev != 0 && bus.grant != grant_prev) begin
                check("grant_release", bus.grant, 0);
                check("release_after_done", done_prev, grant_prev);
            end
            if (grant_prev == 0 && bus.grant != 0) begin
                m_w = (req_prev == 2'b11) ? rr_model : (req_prev[1] ? 1 : 0);
                check("grant_winner", bus.grant, 32'(1) << m_w);
                check("fetch_cs", bus.ram_cs, 1);
                check("fetch_no_valid", bus.out_valid, 0);
                if (qsize(m_w) == 0) check("grant_without_packet", 1, 0);
                else check("fetch_addr", bus.ram_address, qfront_addr(m_w));
                fetch_prev = 1'b1;
            end

            m_acc      = bus.out_valid & bus.out_ready;
            m_done_exp = '0;
            m_ovr_exp  = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (m_acc[i]) begin
                    acc_cnt[i]++;
                    if (qsize(i) == 0) begin
                        check("unexpected_flit", 1, 0);
                    end else begin
                        qpop(i, m_f);
                        check("flit_data", bus.out_data, m_f.data);
                        check("flit_tail", bus.out_tail, m_f.tail);
                        if (m_f.last) begin
                            m_done_exp[i] = 1'b1;
                            m_ovr_exp     = m_f.ovr;
                            rr_model      = (i + 1) % NR;
                            done_cnt[i]++;
                            check("last_no_read", bus.ram_cs, 0);
                        end else begin
                            m_next = m_f.addr + 1'b1;
                            check("stream_read", bus.ram_cs, 1);
                            check("next_addr", bus.ram_address, m_next);
                        end
                    end
                end
            end
            check("done", bus.done, m_done_exp);
            check("err_overrun", bus.err_overrun, m_ovr_exp);
            if (bus.out_valid != 0 && m_acc == 0) check("stall_no_read", bus.ram_cs, 0);
            if (prev_stall && bus.out_valid != 0) begin
                check("stall_hold_data", bus.out_data, prev_data);
                check("stall_hold_tail", bus.out_tail, prev_tail);
            end
            prev_stall = (bus.out_valid != 0) && (m_acc == 0);
            prev_data  = bus.out_data;
            prev_tail  = bus.out_tail;
            grant_prev = bus.grant;
            done_prev  = bus.done;
            req_prev   = bus.req;
            cs_count   = cs_count + 32'(bus.ram_cs);
        end
    end

    // ---------------- driver ----------------
    int done_seen [NR];
    bit rand_ready = 1'b0;

    task automatic step(output logic [NR-1:0] dropped);
        @(posedge clk);
        #1;
        dropped = '0;
        for (int i = 0; i < NR; i++) begin
            if (done_cnt[i] != done_seen[i]) begin
                bus.req[i]   = 1'b0;
                done_seen[i] = done_cnt[i];
                dropped[i]   = 1'b1;
            end
        end
        if (rand_ready) begin
            for (int i = 0; i < NR; i++) bus.out_ready[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Reference packet: consecutive addresses from start, ending at tail or at the flit cap.
    task automatic issue(input int i, input logic [AW-1:0] start);
        flit_t         f;
        logic [AW-1:0] p;
        p = start;
        for (int k = 0; k < MF; k++) begin
            f.data = mem_data[p];
            f.tail = mem_tail[p];
            f.addr = p;
            f.last = mem_tail[p] || (k == MF - 1);
            f.ovr  = !mem_tail[p] && (k == MF - 1);
            qpush(i, f);
            if (f.last) break;
            p = p + 1'b1;
        end
        bus.req_addr[i*AW +: AW] = start;
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int            n;
        logic [NR-1:0] d;
        n = 0;
        while ((bus.req != 0 || qsize(0) != 0 || qsize(1) != 0 || bus.grant != 0) && n < budget) begin
            step(d);
            n++;
        end
        if (n >= budget) begin
            check({name, "_timeout"}, 1, 0);
            bus.req = '0;
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic wait_acc(input int i, input int target, input string name);
        int            n;
        logic [NR-1:0] d;
        n = 0;
        while (acc_cnt[i] < target && n < 200) begin
            step(d);
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic t);
        mem_data[a] = d;
        mem_tail[a] = t;
    endtask

    initial begin
        logic [NR-1:0] d;
        int            cs0;
        int            base;

        #900000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] d;
        int            cs0;
        int            base;

        for (int a = 0; a < 256; a++) begin
            mem_data[a] = DW'($urandom);
            mem_tail[a] = 1'b0;
        end
        for (int i = 0; i < NR; i++) done_seen[i] = 0;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.out_ready = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err_overrun, 0);
        check("rst_cs", bus.ram_cs, 0);
        check("rst_oe", bus.ram_oe, 0);
        check("rst_addr", bus.ram_address, 0);
        rst_n = 1'b1;
        step(d);

        // Single 3-flit packet
        put(8'h10, 16'h00A0, 1'b0);
        put(8'h11, 16'h00A1, 1'b0);
        put(8'h12, 16'h00A2, 1'b1);
        bus.out_ready = '1;
        cs0 = cs_count;
        issue(0, 8'h10);
        step(d);
        check("single_grant_t1", bus.grant, 2'b01);
        check("single_fetch_addr", bus.ram_address, 8'h10);
        step(d);
        check("single_valid_t2", bus.out_valid, 2'b01);
        check("single_first_data", bus.out_data, 16'h00A0);
        wait_idle("single", 100);
        check("single_cs_cycles", cs_count - cs0, 3);

        // Simultaneous requests straight out of reset
        rst_n = 1'b0;
        step(d);
        rst_n = 1'b1;
        put(8'h20, 16'h00B0, 1'b0);
        put(8'h21, 16'h00B1, 1'b1);
        base = done_cnt[1];
        issue(0, 8'h10);
        issue(1, 8'h20);
        wait_idle("simul", 200);
        check("simul_done1", done_cnt[1] - base, 1);

        // Backpressure after the 2nd flit
        for (int k = 0; k < 5; k++) put(8'(8'h30 + k), 16'h00C0 + 16'(k), k == 4);
        issue(0, 8'h30);
        base = acc_cnt[0];
        wait_acc(0, base + 2, "bp");
        bus.out_ready[0] = 1'b0;
        repeat (3) step(d);
        check("bp_stalled", acc_cnt[0] - base, 2);
        bus.out_ready[0] = 1'b1;
        wait_idle("bp", 100);

        // Address wrap 0xFF -> 0x00 -> 0x01
        put(8'hFF, 16'h00D0, 1'b0);
        put(8'h00, 16'h00D1, 1'b0);
        put(8'h01, 16'h00D2, 1'b1);
        base = acc_cnt[0];
        issue(0, 8'hFF);
        wait_idle("wrap", 100);
        check("wrap_flits", acc_cnt[0] - base, 3);

        // Overrun: no tail for 64+ flits from 0x40
        base = acc_cnt[0];
        rand_ready = 1'b1;
        issue(0, 8'h40);
        wait_idle("overrun", 2000);
        check("overrun_flits", acc_cnt[0] - base, 64);
        rand_ready = 1'b0;
        bus.out_ready = '1;

        // Reset during the 2nd flit
        put(8'h53, 16'h00E3, 1'b1);
        base = acc_cnt[0];
        issue(0, 8'h50);
        wait_acc(0, base + 1, "rst_mid");
        rst_n = 1'b0;
        #1;
        check("rstmid_grant", bus.grant, 0);
        check("rstmid_valid", bus.out_valid, 0);
        check("rstmid_done", bus.done, 0);
        check("rstmid_err", bus.err_overrun, 0);
        check("rstmid_cs", bus.ram_cs, 0);
        q0.delete();
        issue(0, 8'h50);
        step(d);
        rst_n = 1'b1;
        step(d);
        check("rstmid_regrant", bus.grant, 2'b01);
        check("rstmid_fetch_addr", bus.ram_address, 8'h50);
        step(d);
        check("rstmid_valid_t2", bus.out_valid, 2'b01);
        wait_idle("rst_mid", 100);

        // Randomised traffic over random memory contents
        for (int a = 0; a < 256; a++) begin
            mem_data[a] = DW'($urandom);
            mem_tail[a] = ($urandom_range(0, 3) == 0);
        end
        rand_ready = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            step(d);
            for (int i = 0; i < NR; i++) begin
                if (!bus.req[i] && !d[i] && qsize(i) == 0 && $urandom_range(0, 2) == 0)
                    issue(i, AW'($urandom));
            end
        end
        wait_idle("random", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
